// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath (register enables, mux selects, ALU decode).
// Define MEM_WAIT_EN to add mem_ready; FETCH, MEMREAD and MEMWRITE then stall until it is high.
module multicycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  input  logic               Lt,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic [2:0]         ImmSrc,
  output logic [3:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALRLINK = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  logic [3:0] state;
  logic [3:0] next_state;
  logic [3:0] dstate;
  logic [1:0] aluop;
  logic       taken;
  logic       mem_rdy;
  logic       alt;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  assign State = STATE_W'(state);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // branch condition from the ALU flags
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = ~Lt;
      default: taken = 1'b0;
    endcase
  end

  // next state and Moore outputs; under reset the outputs decode as FETCH
  always_comb begin
    dstate     = reset ? S_FETCH : state;
    next_state = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    aluop      = ALUOP_ADD;
    case (dstate)
      S_FETCH: begin
        IRWrite    = mem_rdy;
        PCWrite    = mem_rdy;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        next_state = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_IMM:            next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          default:           next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = mem_rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        next_state = mem_rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        aluop      = ALUOP_FN;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        aluop      = ALUOP_FN;
        next_state = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        aluop   = ALUOP_SUB;
        PCWrite = taken;
      end
      S_JAL: begin
        PCWrite    = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        next_state = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        next_state = S_JALRLINK;
      end
      S_JALRLINK: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // immediate format from the opcode
  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      default:   ImmSrc = 3'b000;
    endcase
  end

  // aludec: {funct3, alt}; alt selects sub (R-type only) or arithmetic right shift
  always_comb begin
    alt        = 1'b0;
    ALUControl = 4'b0000;
    case (aluop)
      ALUOP_SUB: ALUControl = 4'b0001;
      ALUOP_FN: begin
        if (funct3 == 3'b101)      alt = funct7b5;
        else if (funct3 == 3'b000) alt = funct7b5 & op[5];
        ALUControl = {funct3, alt};
      end
      default: ALUControl = 4'b0000;
    endcase
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM for the multicycle RV32I datapath: one ALU, one unified instruction/data memory, plus IR, OldPC, A, WriteData, Data and ALUOut registers. Each instruction takes 3–5 states, and the FSM drives the register enables and datapath muxes in each state. ALUControl comes from the existing aludec decoder. Zero and Lt from the ALU resolve branches.

Parameters:
STATE_W, 4, width of the State debug output; must be >= 4.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
Zero  in  1  ALU result == 0
Lt  in  1  ALU signed rs1 < rs2
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0 = PC, 1 = Result
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR/OldPC enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4
RegWrite  out  1  register file write enable
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J
ALUControl  out  4  aludec encoding; add = 0000, sub = 0001
State  out  STATE_W  current state encoding (debug)

Behaviour:
- Clock, reset and polarity: one clock, clk. reset is synchronous and active-high.
- Reset: State <= FETCH (0) on the clk edge while reset = 1.
  - While reset = 1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - All other outputs show their FETCH values.
- Defaults in every state unless listed: all enables 0, AdrSrc 0, ResultSrc 00, ALUSrcA 00, ALUSrcB 00, ALUOp add.
- ImmSrc is decoded from op in all states: lw/jalr/OP-IMM = I, sw = S, branch = B, jal = J, others 000.
- States and encodings:
  - FETCH (0): IRWrite = 1, PCWrite = 1, ALUSrcB = 10, ResultSrc = 10 (PC <= PC+4). Next: DECODE.
  - DECODE (1): ALUSrcA = 01, ALUSrcB = 01, add (ALUOut <= OldPC+imm). Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - any other op -> FETCH (illegal op, no architectural write)
  - MEMADR (2): ALUSrcA = 10, ALUSrcB = 01, add. Next: op[5] = 0 -> MEMREAD, op[5] = 1 -> MEMWRITE.
  - MEMREAD (3): AdrSrc = 1. Next: MEMWB.
  - MEMWB (4): ResultSrc = 01, RegWrite = 1. Next: FETCH.
  - MEMWRITE (5): AdrSrc = 1, MemWrite = 1. Next: FETCH.
  - EXECR (6): ALUSrcA = 10, ALUSrcB = 00, ALUOp from funct3/funct7b5. Next: ALUWB.
  - EXECI (7): ALUSrcA = 10, ALUSrcB = 01, ALUOp from funct3/funct7b5. Next: ALUWB.
  - ALUWB (8): RegWrite = 1. Next: FETCH.
  - BRANCH (9): ALUSrcA = 10, ALUSrcB = 00, sub. PCWrite = taken. Next: FETCH.
    - taken: beq = Zero, bne = ~Zero, blt = Lt, bge = ~Lt.
    - Other funct3 values are never taken.
  - JAL (10): PCWrite = 1 (PC <= ALUOut); ALUSrcA = 01, ALUSrcB = 10, add (ALUOut <= OldPC+4). Next: ALUWB.
  - JALR (11): ALUSrcA = 10, ALUSrcB = 01, add, ResultSrc = 10, PCWrite = 1. Next: JALRLINK.
  - JALRLINK (12): ALUSrcA = 01, ALUSrcB = 10, add. Next: ALUWB.
  - Encodings 13–15: next state FETCH, all outputs at defaults.
- Latency in cycles: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, illegal 2.
- Outputs are Moore outputs of State. The one exception is BRANCH PCWrite, which is combinational on Zero/Lt.
- jalr with rd == rs1: the target uses rs1 latched in A, so the later RegWrite cannot corrupt it.
- Reset mid-instruction: the instruction is abandoned, no write is issued in the reset cycle, and execution restarts at FETCH.

Optional Feature:
MEM_WAIT_EN.
- Defined: adds input mem_ready (1 bit). FETCH, MEMREAD and MEMWRITE hold while mem_ready = 0.
  - FETCH: IRWrite and PCWrite are asserted only in the cycle mem_ready = 1.
  - MEMWRITE: MemWrite is held high until the accepting cycle.
  - MEMREAD: advances only on mem_ready = 1.
- Undefined: the port is absent and memory is single-cycle, as listed above.

Test Plan:
1. reset held 2 cycles, then lw x5,8(x1) (op 0000011) -> State 0,1,2,3,4,0; RegWrite = 1 only in state 4 with ResultSrc = 01.
2. add x3,x1,x2 then sub (funct7b5 = 1) -> EXECR shows ALUControl 0000, then 0001 for sub; ALUWB RegWrite = 1; 4 cycles each.
3. beq with Zero = 1, then with Zero = 0; blt with Lt = 1 -> PCWrite = 1/0/1 in BRANCH; 3 cycles each.
4. jal, then jalr (op 1100111) -> jal path 0,1,10,8; jalr path 0,1,11,12,8; PCWrite in states 10 and 11; RegWrite only in 8.
5. op = 1111111, then reset asserted in MEMWRITE -> illegal op returns to FETCH after DECODE with no writes; MemWrite = 0 in the reset cycle and State = 0 next cycle.
6. (MEM_WAIT_EN) sw with mem_ready low for 3 cycles -> MemWrite high for 4 cycles; State 5 held until mem_ready = 1, then 0.
